// File: rtl/song_sequencer.sv
// song_sequencer: beat-accurate, pausable playback of a song held in a synchronous ROM.
// Each ROM entry {dur, fullnote} sounds for dur beats, followed by GAP_TICKS silent beats.
// An entry with dur == 0 marks the end of the song. Song 0 occupies the lower half of the
// address space and song 1 the upper half.
//
// Ports:
//   clk          system clock
//   RESET        asynchronous, active-high reset
//   beat_tick    one-clk pulse per beat
//   play_toggle  one-clk play/pause request
//   song_sel     song select level (0 = lower half, 1 = upper half)
//   rom_addr     registered song ROM address
//   rom_data     {dur, fullnote} from ROM, usable two edges after rom_addr changes
//   fullnote     note to the tone generator, 0 = silence
//   note_strobe  one-clk pulse when a new ROM entry is loaded
//   playing      high while fetching, loading, playing or in the gap
//   song_done    high once the end of the song is reached
module song_sequencer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DUR_W     = 4,
    parameter int unsigned GAP_TICKS = 1,
    parameter bit          LOOP      = 1'b0
) (
    input  logic                clk,
    input  logic                RESET,
    input  logic                beat_tick,
    input  logic                play_toggle,
    input  logic                song_sel,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [8+DUR_W-1:0]  rom_data,
    output logic [7:0]          fullnote,
    output logic                note_strobe,
    output logic                playing,
    output logic                song_done
);

    localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StLoad, StPlay, StGap, StPaused, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   base, new_base;
    logic [7:0]          note_q, note_d;
    logic [7:0]          entry_q, entry_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                strobe_q, strobe_d;
    logic                pend_q, pend_d;
    logic                resume_gap_q, resume_gap_d;
    logic                playing_q, done_q, sel_q;

    logic [7:0]          rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                song_change, last_slot, advance, end_song;

    assign rom_note    = rom_data[7:0];
    assign rom_dur     = rom_data[8 +: DUR_W];
    assign base        = {sel_q, {(ADDR_W-1){1'b0}}};
    assign new_base    = {song_sel, {(ADDR_W-1){1'b0}}};
    assign song_change = (song_sel != sel_q);
    // Last slot of the current half: advancing past it would cross into the other song.
    assign last_slot   = &addr_q[ADDR_W-2:0];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        note_d       = note_q;
        entry_d      = entry_q;
        dur_d        = dur_q;
        gap_d        = gap_q;
        strobe_d     = 1'b0;
        pend_d       = pend_q;
        resume_gap_d = resume_gap_q;
        advance      = 1'b0;
        end_song     = 1'b0;

        if (song_change) begin
            // Song change overrides everything, including a same-cycle play_toggle.
            state_d = StIdle;
            addr_d  = new_base;
            note_d  = 8'd0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    note_d = 8'd0;
                    if (play_toggle) begin
                        addr_d  = base;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (play_toggle) pend_d = ~pend_q;
                    state_d = StLoad;
                end
                StLoad: begin
                    pend_d = 1'b0;
                    if (rom_dur == '0) begin
                        end_song = 1'b1;
                    end else begin
                        entry_d  = rom_note;
                        dur_d    = rom_dur;
                        strobe_d = 1'b1;
                        // A toggle arriving in this very cycle counts toward the pending pause.
                        if (pend_q ^ play_toggle) begin
                            note_d       = 8'd0;
                            resume_gap_d = 1'b0;
                            state_d      = StPaused;
                        end else begin
                            note_d  = rom_note;
                            state_d = StPlay;
                        end
                    end
                end
                StPlay: begin
                    if (play_toggle) begin
                        // Pause wins over a simultaneous beat_tick.
                        note_d       = 8'd0;
                        resume_gap_d = 1'b0;
                        state_d      = StPaused;
                    end else if (beat_tick) begin
                        dur_d = dur_q - DUR_W'(1);
                        if (dur_q == DUR_W'(1)) begin
                            note_d = 8'd0;
                            if (GAP_TICKS == 0) begin
                                advance = 1'b1;
                            end else begin
                                gap_d   = GAP_W'(GAP_TICKS);
                                state_d = StGap;
                            end
                        end
                    end
                end
                StGap: begin
                    note_d = 8'd0;
                    if (play_toggle) begin
                        resume_gap_d = 1'b1;
                        state_d      = StPaused;
                    end else if (beat_tick) begin
                        gap_d = gap_q - GAP_W'(1);
                        if (gap_q == GAP_W'(1)) advance = 1'b1;
                    end
                end
                StPaused: begin
                    note_d = 8'd0;
                    if (play_toggle) begin
                        if (resume_gap_q) begin
                            state_d = StGap;
                        end else begin
                            note_d  = entry_q;
                            state_d = StPlay;
                        end
                    end
                end
                StDone: begin
                    note_d = 8'd0;
                    if (play_toggle) begin
                        addr_d  = base;
                        state_d = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (advance) begin
                if (last_slot) begin
                    end_song = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StFetch;
                end
            end

            if (end_song) begin
                if (LOOP) begin
                    addr_d  = base;
                    state_d = StFetch;
                end else begin
                    state_d = StDone;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            note_q       <= 8'd0;
            entry_q      <= 8'd0;
            dur_q        <= '0;
            gap_q        <= '0;
            strobe_q     <= 1'b0;
            pend_q       <= 1'b0;
            resume_gap_q <= 1'b0;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            note_q       <= note_d;
            entry_q      <= entry_d;
            dur_q        <= dur_d;
            gap_q        <= gap_d;
            strobe_q     <= strobe_d;
            pend_q       <= pend_d;
            resume_gap_q <= resume_gap_d;
            playing_q    <= (state_d inside {StFetch, StLoad, StPlay, StGap});
            done_q       <= (state_d == StDone);
            sel_q        <= song_sel;
        end
    end

    assign rom_addr    = addr_q;
    assign fullnote    = note_q;
    assign note_strobe = strobe_q;
    assign playing     = playing_q;
    assign song_done   = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: randomized and directed playback scenarios for song_sequencer, checked
// against a beat-level model: the expected note for every beat is derived from the bench's
// own ROM image (dur beats of the note, then GAP silent beats per entry).
module tb_song_sequencer;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 4;
    localparam int unsigned GAP = 1;

    logic          clk = 1'b0;
    logic          RESET = 1'b1;
    logic          beat_tick = 1'b0;
    logic          play_toggle = 1'b0;
    logic          song_sel = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [8+DW-1:0] rom_data;
    logic [7:0]    fullnote;
    logic          note_strobe, playing, song_done;

    logic [8+DW-1:0] rom [0:255];

    int   checks = 0;
    int   errors = 0;
    int   strobe_cnt = 0;
    bit   watch_hi = 1'b0;
    bit   saw_hi = 1'b0;
    logic [7:0] exp_q[$];
    int   n_ent;

    song_sequencer #(
        .ADDR_W    (AW),
        .DUR_W     (DW),
        .GAP_TICKS (GAP),
        .LOOP      (1'b0)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .beat_tick   (beat_tick),
        .play_toggle (play_toggle),
        .song_sel    (song_sel),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .fullnote    (fullnote),
        .note_strobe (note_strobe),
        .playing     (playing),
        .song_done   (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(negedge clk) begin
        if (note_strobe) strobe_cnt++;
        if (watch_hi && rom_addr[AW-1]) saw_hi = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        beat_tick = 1'b1;
        step();
        beat_tick = 1'b0;
    endtask

    task automatic toggle();
        play_toggle = 1'b1;
        step();
        play_toggle = 1'b0;
    endtask

    task automatic select(input logic s);
        song_sel = s;
        step();
        step();
    endtask

    // Beat-level model: the note heard during each beat of the song starting at base.
    task automatic build_model(input int base);
        logic [8+DW-1:0] e;
        exp_q.delete();
        n_ent = 0;
        for (int i = 0; i < 128; i++) begin
            e = rom[base + i];
            if (e[8 +: DW] == 0) break;
            n_ent++;
            for (int k = 0; k < int'(e[8 +: DW]); k++) exp_q.push_back(e[7:0]);
            for (int k = 0; k < int'(GAP); k++) exp_q.push_back(8'd0);
        end
    endtask

    task automatic run_song(input int pause_pct);
        int         s0;
        bit         alt;
        logic [AW-1:0] addr0;
        build_model(song_sel ? 128 : 0);
        s0  = strobe_cnt;
        alt = 1'b1;
        toggle();
        step();
        step();
        checks++;
        if (fullnote !== exp_q[0]) begin
            errors++;
            $display("FAIL latency: fullnote=%0d expected %0d", fullnote, exp_q[0]);
        end
        for (int b = 0; b < exp_q.size(); b++) begin
            if (b > 0) begin
                step();
                step();
                repeat ($urandom_range(0, 3)) step();
            end
            checks++;
            if (fullnote !== exp_q[b]) begin
                errors++;
                $display("FAIL beat_note b=%0d: fullnote=%0d expected %0d", b, fullnote, exp_q[b]);
            end
            if (int'($urandom_range(0, 99)) < pause_pct) begin
                addr0       = rom_addr;
                play_toggle = 1'b1;
                beat_tick   = alt;
                step();
                play_toggle = 1'b0;
                beat_tick   = 1'b0;
                alt         = ~alt;
                checks++;
                if ({fullnote, playing} !== 9'd0) begin
                    errors++;
                    $display("FAIL pause_state: fullnote=%0d playing=%0b expected 0 0",
                             fullnote, playing);
                end
                repeat ($urandom_range(1, 5)) begin
                    step();
                    tick();
                end
                checks++;
                if (rom_addr !== addr0 || fullnote !== 8'd0) begin
                    errors++;
                    $display("FAIL pause_frozen: rom_addr=%0h fullnote=%0d expected %0h 0",
                             rom_addr, fullnote, addr0);
                end
                toggle();
                checks++;
                if (fullnote !== exp_q[b]) begin
                    errors++;
                    $display("FAIL resume_note b=%0d: fullnote=%0d expected %0d",
                             b, fullnote, exp_q[b]);
                end
            end
            tick();
        end
        step();
        step();
        step();
        checks++;
        if ({song_done, playing, fullnote} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL song_end: done=%0b playing=%0b fullnote=%0d expected 1 0 0",
                     song_done, playing, fullnote);
        end
        checks++;
        if (strobe_cnt - s0 !== n_ent) begin
            errors++;
            $display("FAIL strobes: count=%0d expected %0d", strobe_cnt - s0, n_ent);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({rom_addr, fullnote, note_strobe, playing, song_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%0h note=%0d strobe=%0b playing=%0b done=%0b",
                     rom_addr, fullnote, note_strobe, playing, song_done);
        end
        RESET = 1'b0;
        step();
        step();
        checks++;
        if ({playing, song_done, fullnote} !== '0) begin
            errors++;
            $display("FAIL reset_idle: playing=%0b done=%0b note=%0d expected 0 0 0",
                     playing, song_done, fullnote);
        end
    endtask

    task automatic test_basic();
        rom[0] = {4'd2, 8'd3};
        rom[1] = {4'd1, 8'd15};
        rom[2] = {4'd0, 8'hAA};
        run_song(0);
        tick();
        step();
        checks++;
        if (song_done !== 1'b1) begin
            errors++;
            $display("FAIL done_held: song_done=%0b expected 1", song_done);
        end
    endtask

    task automatic test_random_songs();
        int base;
        int len;
        for (int s = 0; s < 4; s++) begin
            select(1'($urandom_range(0, 1)));
            base = song_sel ? 128 : 0;
            len  = $urandom_range(1, 5);
            for (int i = 0; i < len; i++)
                rom[base + i] = {4'($urandom_range(1, 4)), 8'($urandom_range(0, 255))};
            rom[base + len] = '0;
            run_song(s == 0 ? 100 : 30);
        end
    endtask

    task automatic test_pause_fetch();
        select(1'b0);
        rom[0] = {4'd3, 8'd77};
        rom[1] = '0;
        play_toggle = 1'b1;
        step();
        step();
        play_toggle = 1'b0;
        step();
        checks++;
        if ({note_strobe, fullnote, playing} !== {1'b1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL pend_pause: strobe=%0b note=%0d playing=%0b expected 1 0 0",
                     note_strobe, fullnote, playing);
        end
        toggle();
        checks++;
        if ({fullnote, playing} !== {8'd77, 1'b1}) begin
            errors++;
            $display("FAIL pend_resume: note=%0d playing=%0b expected 77 1", fullnote, playing);
        end
        repeat (2) begin
            step();
            tick();
        end
        checks++;
        if (fullnote !== 8'd77) begin
            errors++;
            $display("FAIL pend_dur: note=%0d expected 77", fullnote);
        end
        tick();
        step();
        checks++;
        if ({fullnote, song_done} !== 9'd0) begin
            errors++;
            $display("FAIL pend_gap: note=%0d done=%0b expected 0 0", fullnote, song_done);
        end
        tick();
        step();
        step();
        step();
        checks++;
        if (song_done !== 1'b1) begin
            errors++;
            $display("FAIL pend_done: song_done=%0b expected 1", song_done);
        end
    endtask

    task automatic test_song_change();
        rom[0]   = {4'd4, 8'd50};
        rom[1]   = '0;
        rom[128] = {4'd2, 8'd99};
        rom[129] = {4'd1, 8'd7};
        rom[130] = '0;
        select(1'b0);
        toggle();
        step();
        step();
        tick();
        step();
        checks++;
        if (fullnote !== 8'd50) begin
            errors++;
            $display("FAIL change_pre: note=%0d expected 50", fullnote);
        end
        song_sel = 1'b1;
        step();
        checks++;
        if ({fullnote, rom_addr, playing} !== {8'd0, 8'h80, 1'b0}) begin
            errors++;
            $display("FAIL change_idle: note=%0d addr=%0h playing=%0b expected 0 80 0",
                     fullnote, rom_addr, playing);
        end
        step();
        run_song(0);
    endtask

    task automatic test_no_marker();
        select(1'b0);
        for (int i = 0; i < 128; i++) rom[i] = {4'd1, 8'($urandom_range(1, 255))};
        watch_hi = 1'b1;
        run_song(0);
        watch_hi = 1'b0;
        checks++;
        if (saw_hi !== 1'b0 || rom_addr !== 8'h7F) begin
            errors++;
            $display("FAIL no_marker: saw_upper=%0b addr=%0h expected 0 7f", saw_hi, rom_addr);
        end
    endtask

    task automatic test_reset_mid_gap();
        select(1'b1);
        rom[128] = {4'd1, 8'd200};
        rom[129] = {4'd1, 8'd201};
        rom[130] = '0;
        toggle();
        step();
        step();
        tick();
        step();
        checks++;
        if ({playing, fullnote, rom_addr} !== {1'b1, 8'd0, 8'h80}) begin
            errors++;
            $display("FAIL gap_pre: playing=%0b note=%0d addr=%0h expected 1 0 80",
                     playing, fullnote, rom_addr);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({rom_addr, fullnote, note_strobe, playing, song_done} !== '0) begin
            errors++;
            $display("FAIL async_reset: addr=%0h note=%0d strobe=%0b playing=%0b done=%0b",
                     rom_addr, fullnote, note_strobe, playing, song_done);
        end
        step();
        RESET = 1'b0;
        repeat (4) step();
        checks++;
        if ({playing, fullnote, song_done, rom_addr} !== {1'b0, 8'd0, 1'b0, 8'h80}) begin
            errors++;
            $display("FAIL post_reset: playing=%0b note=%0d done=%0b addr=%0h",
                     playing, fullnote, song_done, rom_addr);
        end
        run_song(0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        repeat (3) step();
        test_reset();
        test_basic();
        test_random_songs();
        test_pause_fetch();
        test_song_change();
        test_no_marker();
        test_reset_mid_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
